// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues commands onto an external combinational 8-bit ALU.
// Stage p0 registers operands and opcode onto the ALU inputs. Stage p1 captures
// the ALU result and flags into a response FIFO and the accumulator.
// Chained commands take operand A from the accumulator. When the previous
// command is still in exec, operand A is forwarded from the live ALU result.
module alu_op_sequencer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero_flag,
  input  logic              alu_carry_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic [DATA_W-1:0] acc_out,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RSP_W = DATA_W + 2;

  logic              vld_p1;
  logic [DATA_W-1:0] acc_p1;
  logic [DATA_W-1:0] a_src_p0;
  logic              accept_p0;
  logic              push_p1;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic [RSP_W-1:0]  fifo_mem [FIFO_DEPTH];

  // The exec slot reserves a FIFO entry, so a push can never overflow.
  // rsp_ready is deliberately not considered here.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
  assign cmd_ready = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign accept_p0 = cmd_valid & cmd_ready;
  assign a_src_p0  = vld_p1 ? alu_result : acc_p1;
  assign push_p1   = vld_p1;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & rsp_ready;

  assign {rsp_result, rsp_zero, rsp_carry} = fifo_mem[rd_ptr];
  assign acc_out = acc_p1;
  assign busy    = vld_p1 | rsp_valid;

  // ---- stage p0: issue, register operands and opcode onto the ALU ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= '0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        alu_a         <= cmd_use_acc ? a_src_p0 : cmd_a;
        alu_b         <= cmd_b;
        alu_operation <= cmd_op;
      end
    end
  end

  // ---- stage p1: exec, accumulator tracks the last completed result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1 <= '0;
    end else if (push_p1) begin
      acc_p1 <= alu_result;
    end
  end

  // Response FIFO pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_p1) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_p1 && !pop) begin
        count <= count + 1'b1;
      end else if (!push_p1 && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // Response storage; cleared on reset so the head reads zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (push_p1) begin
      fifo_mem[wr_ptr] <= {alu_result, alu_zero_flag, alu_carry_flag};
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a stand-in ALU drives alu_result and the flags.
// Expected responses are queued at command accept and compared when popped.
module tb_alu_op_sequencer;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  localparam logic [2:0] OP_PASS_A = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_AND    = 3'd3;
  localparam logic [2:0] OP_OR     = 3'd4;
  localparam logic [2:0] OP_XOR    = 3'd5;
  localparam logic [2:0] OP_PASS_B = 3'd6;
  localparam logic [2:0] OP_NOT_A  = 3'd7;

  typedef struct packed {
    logic [7:0] result;
    logic       zero;
    logic       carry;
  } rsp_t;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_use_acc;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_operation;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero_flag;
  logic              alu_carry_flag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_carry;
  logic [DATA_W-1:0] acc_out;
  logic              busy;

  int         errors;
  int         checks;
  int         accepts;
  int         pops;
  rsp_t       sb_q[$];
  logic [7:0] rsp_log[$];
  logic [7:0] model_acc;
  rsp_t       alu_r;

  alu_op_sequencer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero_flag(alu_zero_flag),
    .alu_carry_flag(alu_carry_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .acc_out(acc_out), .busy(busy)
  );

  function automatic rsp_t alu_ref(input logic [2:0] op, input logic [7:0] a,
                                   input logic [7:0] b);
    logic [8:0] w;
    rsp_t       r;
    case (op)
      OP_PASS_A: w = {1'b0, a};
      OP_ADD:    w = {1'b0, a} + {1'b0, b};
      OP_SUB:    w = {1'b0, a} - {1'b0, b};
      OP_AND:    w = {1'b0, a & b};
      OP_OR:     w = {1'b0, a | b};
      OP_XOR:    w = {1'b0, a ^ b};
      OP_PASS_B: w = {1'b0, b};
      OP_NOT_A:  w = {1'b0, ~a};
      default:   w = '0;
    endcase
    r.result = w[7:0];
    r.zero   = (w[7:0] == 8'h00);
    r.carry  = (op == OP_ADD || op == OP_SUB) ? w[8] : 1'b0;
    return r;
  endfunction

  // Stand-in combinational ALU fed by the DUT's registered ALU inputs.
  always_comb begin
    alu_r = alu_ref(alu_operation, alu_a, alu_b);
  end
  assign alu_result     = alu_r.result;
  assign alu_zero_flag  = alu_r.zero;
  assign alu_carry_flag = alu_r.carry;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard work at the negedge, then return just after the posedge.
  task automatic tick();
    rsp_t       exp;
    rsp_t       r;
    logic [7:0] a_val;
    @(negedge clk);
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        assert (sb_q.size() > 0) else begin
          errors++;
          $error("FAIL sb_unexpected_rsp observed=0x%0h expected=none", rsp_result);
        end
        if (sb_q.size() > 0) begin
          exp = sb_q.pop_front();
          check("rsp_result", 32'(rsp_result), 32'(exp.result));
          check("rsp_zero",   32'(rsp_zero),   32'(exp.zero));
          check("rsp_carry",  32'(rsp_carry),  32'(exp.carry));
        end
        rsp_log.push_back(rsp_result);
        pops++;
      end
      if (cmd_valid && cmd_ready) begin
        a_val     = cmd_use_acc ? model_acc : cmd_a;
        r         = alu_ref(cmd_op, a_val, cmd_b);
        model_acc = r.result;
        sb_q.push_back(r);
        accepts++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic use_acc);
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic use_acc);
    int n;
    set_cmd(op, a, b, use_acc);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check("issue_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int   i;
    int   cyc;
    int   base;
    logic go;
    logic need_new;

    errors = 0; checks = 0; accepts = 0; pops = 0; model_acc = 8'h00;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    set_cmd(3'd0, 8'h00, 8'h00, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_b", 32'(alu_b), 32'h0);
    check("rst_alu_op", 32'(alu_operation), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_fields", 32'({rsp_result, rsp_zero, rsp_carry}), 32'h0);
    check("rst_acc", 32'(acc_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ADD 0xF0 + 0x20, two-clock latency
    rsp_ready = 1'b1;
    set_cmd(OP_ADD, 8'hF0, 8'h20, 1'b0);
    cmd_valid = 1'b1;
    check("add_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("add_lat_n", 32'(rsp_valid), 32'd0);
    tick();
    check("add_lat_n1", 32'(rsp_valid), 32'd1);
    check("add_result", 32'(rsp_result), 32'h10);
    check("add_carry", 32'(rsp_carry), 32'd1);
    check("add_zero", 32'(rsp_zero), 32'd0);
    check("add_acc", 32'(acc_out), 32'h10);
    drain();

    // SUB / NOT boundary flags
    issue(OP_SUB, 8'h05, 8'h05, 1'b0);
    drain();
    check("sub_eq_acc", 32'(acc_out), 32'h00);
    issue(OP_SUB, 8'h03, 8'h05, 1'b0);
    drain();
    check("sub_borrow_acc", 32'(acc_out), 32'hFE);
    issue(OP_NOT_A, 8'hFF, 8'h00, 1'b0);
    drain();
    check("not_acc", 32'(acc_out), 32'h00);

    // Back-to-back chain through the forwarding path
    rsp_log.delete();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    set_cmd(OP_PASS_B, 8'hAA, 8'h01, 1'b0);
    check("chain_ready0", 32'(cmd_ready), 32'd1);
    tick();
    set_cmd(OP_ADD, 8'hAA, 8'h02, 1'b1);
    check("chain_ready1", 32'(cmd_ready), 32'd1);
    tick();
    set_cmd(OP_ADD, 8'hAA, 8'hFF, 1'b1);
    check("chain_ready2", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    drain();
    check("chain_count", 32'(rsp_log.size()), 32'd3);
    if (rsp_log.size() == 3) begin
      check("chain_rsp0", 32'(rsp_log[0]), 32'h01);
      check("chain_rsp1", 32'(rsp_log[1]), 32'h03);
      check("chain_rsp2", 32'(rsp_log[2]), 32'h02);
    end
    check("chain_acc", 32'(acc_out), 32'h02);

    // Backpressure: six held commands, consumer stalled
    rsp_log.delete();
    rsp_ready = 1'b0;
    i = 0;
    cyc = 0;
    while (i < 6 && cyc < 12) begin
      set_cmd(OP_PASS_A, 8'(8'h31 + 7 * i), 8'h00, 1'b0);
      cmd_valid = 1'b1;
      go = cmd_ready;
      tick();
      if (go) i++;
      cyc++;
    end
    check("bp_accepted", 32'(i), 32'd4);
    check("bp_ready_low", 32'(cmd_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    cyc = 0;
    while (i < 6 && cyc < 50) begin
      set_cmd(OP_PASS_A, 8'(8'h31 + 7 * i), 8'h00, 1'b0);
      cmd_valid = 1'b1;
      go = cmd_ready;
      tick();
      if (go) i++;
      cyc++;
    end
    cmd_valid = 1'b0;
    drain();
    check("bp_rsp_count", 32'(rsp_log.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < rsp_log.size()) check("bp_rsp_order", 32'(rsp_log[k]), 32'(8'(8'h31 + 7 * k)));
    end
    check("bp_ready_back", 32'(cmd_ready), 32'd1);

    // Reset with two queued responses and one in exec
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    set_cmd(OP_PASS_A, 8'h11, 8'h00, 1'b0);
    tick();
    set_cmd(OP_PASS_A, 8'h22, 8'h00, 1'b0);
    tick();
    set_cmd(OP_PASS_A, 8'h33, 8'h00, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("prerst_busy", 32'(busy), 32'd1);
    check("prerst_acc", 32'(acc_out), 32'h22);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_acc", 32'(acc_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    model_acc = 8'h00;
    rst_n = 1'b1;
    tick();
    check("postrst_ready", 32'(cmd_ready), 32'd1);
    check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    issue(OP_ADD, 8'hEE, 8'h05, 1'b1);
    drain();
    check("postrst_acc", 32'(acc_out), 32'h05);

    // Random valid/ready traffic, 1000 commands
    base = accepts;
    cyc = 0;
    need_new = 1'b1;
    while ((accepts - base) < 1000 && cyc < 30000) begin
      if (need_new) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        set_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      go = cmd_valid && cmd_ready;
      tick();
      need_new = go || !cmd_valid;
      cyc++;
    end
    cmd_valid = 1'b0;
    check("rand_accepted", 32'(accepts - base), 32'd1000);
    drain();
    check("rand_acc", 32'(acc_out), 32'(model_acc));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-issue and result-collection stage wrapped around the 8-bit combinational ALU (opcodes 000 pass A … 111 NOT A).
- Accepts operation commands over a valid/ready interface and registers operands/opcode onto the ALU inputs.
- Captures the ALU result and flags one cycle later.
- Queues responses in a small FIFO toward a valid/ready consumer.
- Keeps an accumulator of the last completed result, so a command may use it as operand A (chained arithmetic), with forwarding.

Parameters:
- DATA_W, 8, operand/result width; must equal ALU width (8); other values unsupported.
- FIFO_DEPTH, 4, response FIFO entries; power of two, >=2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_op  in  3  ALU opcode
- cmd_a  in  DATA_W  operand A (ignored when cmd_use_acc=1)
- cmd_b  in  DATA_W  operand B
- cmd_use_acc  in  1  take operand A from the accumulator
- alu_a  out  DATA_W  registered operand A to ALU
- alu_b  out  DATA_W  registered operand B to ALU
- alu_operation  out  3  registered opcode to ALU
- alu_result  in  DATA_W  ALU result (combinational from alu_* outputs)
- alu_zero_flag  in  1  ALU zero flag
- alu_carry_flag  in  1  ALU carry flag
- rsp_valid  out  1  response available (FIFO non-empty)
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  DATA_W  FIFO head result
- rsp_zero  out  1  FIFO head zero flag
- rsp_carry  out  1  FIFO head carry flag
- acc_out  out  DATA_W  current accumulator value
- busy  out  1  exec stage valid or FIFO non-empty

Behaviour:
- Reset (async assert, sync-released use): alu_a/alu_b/alu_operation=0, exec_v=0, FIFO empty (count=0, pointers 0), rsp_valid=0, rsp_* =0, acc_out=0, busy=0, cmd_ready reflects empty state (=1 once rst_n high).
- Reset mid-operation: in-flight exec and all queued responses discarded; accumulator cleared.
- Stage 0 (issue), on accept at edge N:
  - alu_a <= (cmd_use_acc ? A_src : cmd_a); alu_b <= cmd_b; alu_operation <= cmd_op; exec_v <= 1.
  - With no accept: exec_v <= 0; alu_* hold last values.
- A_src forwarding: if exec_v=1 at accept, A_src = alu_result (in-flight value), else acc_out. Back-to-back chained commands therefore see the immediately preceding result with no bubble.
- Stage 1 (exec), at edge N+1 when exec_v=1:
  - Push {alu_result, alu_zero_flag, alu_carry_flag} into FIFO.
  - acc_out <= alu_result.
- Latency: accept at edge N -> rsp_valid=1 during cycle after edge N+1 (2 clocks) when FIFO was empty.
- Throughput: one command per clock while responses drain.
- cmd_ready = (count + exec_v) < FIFO_DEPTH, combinational from registered state only; never depends on cmd_valid. In-flight exec always has a guaranteed slot, so a push never overflows.
- Pop on rsp_valid&rsp_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. At full with simultaneous pop: pop frees no slot for the same-cycle cmd_ready (cmd_ready does not look at rsp_ready).
- Pop on empty: impossible; rsp_valid=0.
- rsp_* are the FIFO head and stay stable while rsp_valid&!rsp_ready.
- Pointer wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
- Flags pass through unmodified. SUB carry = bit 8 of the 9-bit difference (1 on borrow). Logic ops carry=0.
- busy = exec_v | (count!=0).

Test Plan:
- Reset mid-flight: rst_n low with 2 queued + 1 in exec -> rsp_valid=0, acc_out=0, busy=0 asynchronously; cmd_ready=1 after release.
- ADD a=0xF0 b=0x20, rsp_ready=1 -> rsp_result=0x10, carry=1, zero=0, rsp_valid exactly 2 clocks after accept; acc_out=0x10.
- SUB 0x05-0x05 -> 0x00, zero=1, carry=0; SUB 0x03-0x05 -> 0xFE, zero=0, carry=1; NOT A a=0xFF -> 0x00, zero=1, carry=0.
- Chained back-to-back, no idle cycles: PASS_B b=0x01; ADD use_acc b=0x02; ADD use_acc b=0xFF -> responses 0x01, 0x03, 0x02 (last carry=1); acc_out=0x02.
- Backpressure (DEPTH=4): rsp_ready=0, cmd_valid held with 6 distinct commands -> exactly 4 accepted, cmd_ready=0 thereafter. Then rsp_ready=1 -> 6 responses in order, no loss or duplication, cmd_ready reasserts.
- Random valid/ready toggling for 1000 commands vs reference model -> in-order match of result/zero/carry including chained use_acc.
